// File: rtl/i2s_frame_sequencer.sv
// Purpose : pairs an I2S left strobe with the next right strobe and streams the
//           frame (optional header word, then L lanes, then R lanes) into a FIFO.
// Latency : R_RDY at cycle t -> first word written at t+1, back-to-back if not full.
// Backpressure: FIFO_FULL stalls EMIT in place for any length; the word is held.
//           New left strobes that cannot be taken are dropped and counted.
// Ports   : USBCLK_IN/RSTN_IN clock and sync active-low reset; STMEN session enable;
//           L_RDY/R_RDY + DATA_L/DATA_R capture strobes and lane-packed samples;
//           FIFO_FULL/FIFO_DATA/FIFO_WR write side; FRAME_ID, ACTIVE, OVERFLOW,
//           DROP_CNT status.
module i2s_frame_sequencer #(
    parameter int LANES    = 2,
    parameter int SAMPLE_W = 24,
    parameter int WORD_W   = 16,
    parameter int HDR_EN   = 1
) (
    input  logic                      USBCLK_IN,
    input  logic                      RSTN_IN,
    input  logic                      STMEN,
    input  logic                      L_RDY,
    input  logic                      R_RDY,
    input  logic [LANES*SAMPLE_W-1:0] DATA_L,
    input  logic [LANES*SAMPLE_W-1:0] DATA_R,
    input  logic                      FIFO_FULL,
    output logic [WORD_W-1:0]         FIFO_DATA,
    output logic                      FIFO_WR,
    output logic [7:0]                FRAME_ID,
    output logic                      ACTIVE,
    output logic                      OVERFLOW,
    output logic [15:0]               DROP_CNT
);

    localparam int N     = HDR_EN + 2 * LANES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_L = 2'd1,
        S_WAIT_R = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [LANES*SAMPLE_W-1:0] snap_l, snap_r;
    logic                      load_l, load_r;
    logic                      drop;
    logic                      new_session;
    logic                      frame_done;
    logic                      wr;
    logic [WORD_W-1:0]         hdr_word;
    logic [WORD_W-1:0]         word;

    // Next-state and control decode. STMEN low wins over capture strobes in the
    // waiting states; EMIT always runs the frame to completion.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        load_l      = 1'b0;
        load_r      = 1'b0;
        drop        = 1'b0;
        new_session = 1'b0;
        frame_done  = 1'b0;
        wr          = 1'b0;
        case (state)
            S_IDLE: begin
                if (STMEN) begin
                    state_nxt   = S_WAIT_L;
                    new_session = 1'b1;
                end
            end
            S_WAIT_L: begin
                if (!STMEN) begin
                    state_nxt = S_IDLE;
                end else if (L_RDY) begin
                    load_l    = 1'b1;
                    state_nxt = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (!STMEN) begin
                    state_nxt = S_IDLE;
                end else if (R_RDY) begin
                    // Right wins over a simultaneous left: the pair completes.
                    load_r    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_EMIT;
                end else if (L_RDY) begin
                    // Previous left never got its right half: replace it.
                    load_l = 1'b1;
                    drop   = 1'b1;
                end
            end
            S_EMIT: begin
                wr   = !FIFO_FULL;
                drop = L_RDY;
                if (wr) begin
                    if (idx == IDX_W'(N - 1)) begin
                        frame_done = 1'b1;
                        idx_nxt    = '0;
                        state_nxt  = STMEN ? S_WAIT_L : S_IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header carries the marker and the id of the frame being emitted, left-aligned.
    always_comb begin
        hdr_word                   = '0;
        hdr_word[WORD_W-1 -: 16]   = {8'hA5, FRAME_ID};
    end

    // Word select; each sample keeps only its top WORD_W bits.
    always_comb begin
        word = '0;
        if (state == S_EMIT) begin
            if (HDR_EN != 0 && idx == '0) begin
                word = hdr_word;
            end
            for (int i = 0; i < LANES; i++) begin
                if (idx == IDX_W'(HDR_EN + i)) begin
                    word = snap_l[i*SAMPLE_W + SAMPLE_W - 1 -: WORD_W];
                end
                if (idx == IDX_W'(HDR_EN + LANES + i)) begin
                    word = snap_r[i*SAMPLE_W + SAMPLE_W - 1 -: WORD_W];
                end
            end
        end
    end

    assign FIFO_DATA = word;
    assign FIFO_WR   = wr;
    assign ACTIVE    = (state != S_IDLE);

    always_ff @(posedge USBCLK_IN) begin
        if (!RSTN_IN) begin
            state    <= S_IDLE;
            idx      <= '0;
            snap_l   <= '0;
            snap_r   <= '0;
            FRAME_ID <= 8'd0;
            OVERFLOW <= 1'b0;
            DROP_CNT <= 16'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load_l) begin
                snap_l <= DATA_L;
            end
            if (load_r) begin
                snap_r <= DATA_R;
            end
            if (new_session) begin
                FRAME_ID <= 8'd0;
                OVERFLOW <= 1'b0;
                DROP_CNT <= 16'd0;
            end else begin
                if (frame_done) begin
                    FRAME_ID <= FRAME_ID + 8'd1;
                end
                if (drop) begin
                    OVERFLOW <= 1'b1;
                    if (DROP_CNT != 16'hFFFF) begin
                        DROP_CNT <= DROP_CNT + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Purpose : directed plus randomized bench for i2s_frame_sequencer (default
//           parameters); a queue-based frame model predicts every output each cycle.
module tb_i2s_frame_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, stmen, l_rdy, r_rdy, full;
    logic [47:0] dl, dr;
    logic [15:0] fdata;
    logic        fwr;
    logic [7:0]  fid;
    logic        act, ovf;
    logic [15:0] dcnt;

    i2s_frame_sequencer #(.LANES(2), .SAMPLE_W(24), .WORD_W(16), .HDR_EN(1)) dut (
        .USBCLK_IN (clk),
        .RSTN_IN   (rstn),
        .STMEN     (stmen),
        .L_RDY     (l_rdy),
        .R_RDY     (r_rdy),
        .DATA_L    (dl),
        .DATA_R    (dr),
        .FIFO_FULL (full),
        .FIFO_DATA (fdata),
        .FIFO_WR   (fwr),
        .FRAME_ID  (fid),
        .ACTIVE    (act),
        .OVERFLOW  (ovf),
        .DROP_CNT  (dcnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: a session flag, a held left pair, and a queue of words still owed.
    bit          m_valid = 1'b0;
    bit          m_on, m_have_l, m_ovf;
    logic [15:0] m_q[$];
    logic [47:0] m_l;
    int          m_fid, m_drop;
    logic [15:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] smp(input logic [47:0] d, input int lane);
        logic [47:0] t;
        t = (d >> (lane * 24 + 8)) & 48'hFFFF;
        return t[15:0];
    endfunction

    task automatic m_drop_one();
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_update();
        if (!rstn) begin
            m_valid = 1'b1; m_on = 0; m_have_l = 0; m_q.delete();
            m_l = '0; m_fid = 0; m_ovf = 0; m_drop = 0;
        end else if (!m_valid) begin
            m_valid = 1'b0;
        end else if (!m_on) begin
            if (stmen) begin
                m_on = 1; m_have_l = 0; m_fid = 0; m_ovf = 0; m_drop = 0;
            end
        end else if (m_q.size() > 0) begin
            if (l_rdy) m_drop_one();
            if (!full) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_fid    = (m_fid + 1) % 256;
                    m_on     = stmen;
                    m_have_l = 0;
                end
            end
        end else if (!stmen) begin
            m_on = 0; m_have_l = 0;
        end else if (!m_have_l) begin
            if (l_rdy) begin m_l = dl; m_have_l = 1; end
        end else if (r_rdy) begin
            m_have_l = 0;
            m_q.push_back({8'hA5, 8'(m_fid)});
            for (int i = 0; i < 2; i++) m_q.push_back(smp(m_l, i));
            for (int i = 0; i < 2; i++) m_q.push_back(smp(dr, i));
        end else if (l_rdy) begin
            m_l = dl;
            m_drop_one();
        end
    endtask

    // One clock: check outputs mid-low-phase, record writes, advance model at the edge.
    task automatic step();
        #1;
        if (m_valid) begin
            chk("fifo_wr",   {31'd0, fwr}, {31'd0, (m_q.size() > 0) && !full});
            chk("fifo_data", {16'd0, fdata}, (m_q.size() > 0) ? {16'd0, m_q[0]} : 32'd0);
            chk("active",    {31'd0, act}, {31'd0, m_on});
            chk("frame_id",  {24'd0, fid}, m_fid);
            chk("overflow",  {31'd0, ovf}, {31'd0, m_ovf});
            chk("drop_cnt",  {16'd0, dcnt}, m_drop);
        end
        if (fwr === 1'b1) wq.push_back(fdata);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic left(input logic [47:0] d);
        dl = d; l_rdy = 1'b1; step(); l_rdy = 1'b0;
    endtask

    task automatic right(input logic [47:0] d);
        dr = d; r_rdy = 1'b1; step(); r_rdy = 1'b0;
    endtask

    localparam logic [47:0] BL = {24'hABCDEF, 24'h123456};
    localparam logic [47:0] BR = {24'h807060, 24'h0F0F0F};
    localparam logic [47:0] X1 = {24'h111111, 24'h222222};
    localparam logic [47:0] X2 = {24'h456789, 24'hFEDCBA};
    localparam logic [47:0] Y  = {24'h333333, 24'h444444};

    logic [15:0] exp5[5];
    logic [15:0] hdr256, hdr257;

    initial begin
        rstn = 0; stmen = 0; l_rdy = 0; r_rdy = 0; full = 0; dl = '0; dr = '0;
        @(negedge clk);
        run(2);
        chk("rst_wr", {31'd0, fwr}, 0);
        chk("rst_data", {16'd0, fdata}, 0);
        chk("rst_fid", {24'd0, fid}, 0);
        chk("rst_active", {31'd0, act}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_drop", {16'd0, dcnt}, 0);

        // Basic frame
        rstn = 1; stmen = 1; run(2);
        wq.delete();
        left(BL); run(10); right(BR); run(6);
        exp5 = '{16'hA500, 16'h1234, 16'hABCD, 16'h0F0F, 16'h8070};
        chk("basic_cnt", wq.size(), 5);
        for (int i = 0; i < 5; i++) chk("basic_word", {16'd0, wq[i]}, {16'd0, exp5[i]});
        chk("basic_fid", {24'd0, fid}, 1);

        // Backpressure during word 2
        wq.delete();
        left(BL); right(BR); run(2);
        full = 1;
        #1;
        chk("bp_hold_data", {16'd0, fdata}, 32'hABCD);
        chk("bp_hold_wr", {31'd0, fwr}, 0);
        run(3);
        full = 0; run(4);
        exp5 = '{16'hA501, 16'h1234, 16'hABCD, 16'h0F0F, 16'h8070};
        chk("bp_cnt", wq.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_word", {16'd0, wq[i]}, {16'd0, exp5[i]});

        // Missing right half: second left replaces the first
        wq.delete();
        left(X1); run(1); left(X2); run(1); right(Y); run(6);
        chk("miss_drop", {16'd0, dcnt}, 1);
        chk("miss_ovf", {31'd0, ovf}, 1);
        chk("miss_l0", {16'd0, wq[1]}, 32'hFEDC);
        chk("miss_l1", {16'd0, wq[2]}, 32'h4567);

        // Left during EMIT: counted, not captured
        wq.delete();
        left(X1); right(Y);
        dl = X2; l_rdy = 1; step(); l_rdy = 0;
        run(5);
        chk("emit_l_drop", {16'd0, dcnt}, 2);
        chk("emit_l_cnt", wq.size(), 5);
        chk("emit_l_w1", {16'd0, wq[1]}, 32'h2222);
        chk("emit_l_w3", {16'd0, wq[3]}, 32'h4444);
        chk("emit_l_fid", {24'd0, fid}, 4);

        // Stop in WAIT_R
        wq.delete();
        left(X1); stmen = 0; step();
        #1 chk("stop_wr_active", {31'd0, act}, 0);
        run(3);
        chk("stop_wr_writes", wq.size(), 0);

        // Restart clears session state
        stmen = 1; step();
        #1;
        chk("restart_fid", {24'd0, fid}, 0);
        chk("restart_ovf", {31'd0, ovf}, 0);
        chk("restart_drop", {16'd0, dcnt}, 0);

        // Stop during EMIT word 1: frame still completes
        wq.delete();
        left(X1); right(Y); step();
        stmen = 0; run(6);
        chk("stop_emit_cnt", wq.size(), 5);
        chk("stop_emit_active", {31'd0, act}, 0);
        chk("stop_emit_fid", {24'd0, fid}, 1);

        // 257 frames in a fresh session
        stmen = 1; step();
        hdr256 = '0; hdr257 = '0;
        for (int f = 0; f < 257; f++) begin
            wq.delete();
            left({16'($urandom), $urandom}); right({16'($urandom), $urandom}); run(5);
            if (f == 255) hdr256 = wq[0];
            if (f == 256) hdr257 = wq[0];
        end
        chk("wrap_fid", {24'd0, fid}, 1);
        chk("wrap_hdr256", {16'd0, hdr256}, 32'hA5FF);
        chk("wrap_hdr257", {16'd0, hdr257}, 32'hA500);

        // Randomized traffic including occasional resets and session toggles
        for (int c = 0; c < 3000; c++) begin
            rstn  = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 49) == 0) stmen = ~stmen;
            l_rdy = ($urandom_range(0, 5) == 0);
            r_rdy = ($urandom_range(0, 5) == 0);
            full  = ($urandom_range(0, 2) == 0);
            dl    = {16'($urandom), $urandom};
            dr    = {16'($urandom), $urandom};
            step();
        end

        // Drop counter saturation
        l_rdy = 0; r_rdy = 0; full = 0; rstn = 0; stmen = 0; step();
        rstn = 1; stmen = 1; step();
        left(X1);
        l_rdy = 1; dl = X2;
        run(65540);
        l_rdy = 0;
        chk("sat_drop", {16'd0, dcnt}, 32'hFFFF);
        chk("sat_ovf", {31'd0, ovf}, 1);

        // Reset mid-EMIT
        wq.delete();
        right(Y); run(2);
        rstn = 0; step();
        #1;
        chk("rst_emit_wr", {31'd0, fwr}, 0);
        chk("rst_emit_data", {16'd0, fdata}, 0);
        chk("rst_emit_active", {31'd0, act}, 0);
        chk("rst_emit_fid", {24'd0, fid}, 0);
        chk("rst_emit_drop", {16'd0, dcnt}, 0);
        chk("rst_emit_writes", wq.size(), 3);
        rstn = 1; run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
